rx_3byte_assembler: RTL and testbench

RX_3BYTE_ASSEMBLER -- requirements
Module: rx_3byte_assembler

---
 rtl/rx_3byte_assembler.sv | 119 +++++++++++
 tb/tb_rx_3byte_assembler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rx_3byte_assembler.sv
// rtl/rx_3byte_assembler.sv - packs three received UART bytes into a 24-bit word with valid/ready handoff
// Optional inter-byte timeout enabled by defining RX3_TIMEOUT_EN.
module rx_3byte_assembler #(
    parameter int TIMEOUT_CYCLES = 26040,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [23:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [1:0]  byte_count,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t     state, state_next;
    logic [7:0] slot0, slot1;
    logic       accept, complete, drop, expire, transfer;

    assign word_valid = (state == HOLD);
    assign transfer   = word_valid && word_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    accept     = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    accept = 1'b1;
                    if (byte_count == 2'd2) begin
                        complete   = 1'b1;
                        state_next = HOLD;
                    end
                end else if (expire) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                // A byte arriving in the same cycle as the handoff starts the next word.
                if (transfer) begin
                    if (rx_valid) begin
                        accept     = 1'b1;
                        state_next = COLLECT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (rx_valid) begin
                    drop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial bytes live in slot0/slot1 so word_out keeps the previous word until a new one completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0      <= 8'h00;
            slot1      <= 8'h00;
            word_out   <= 24'h000000;
            byte_count <= 2'd0;
            overrun    <= 1'b0;
        end else begin
            overrun <= drop;
            if (complete) begin
                word_out   <= MSB_FIRST ? {slot0, slot1, rx_byte} : {rx_byte, slot1, slot0};
                byte_count <= 2'd0;
            end else if (accept) begin
                if (byte_count == 2'd0) slot0 <= rx_byte;
                else                    slot1 <= rx_byte;
                byte_count <= byte_count + 2'd1;
            end else if (expire) begin
                byte_count <= 2'd0;
            end
        end
    end

`ifdef RX3_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tcnt;

    // rx_valid in the expiry cycle wins over the timeout.
    assign expire = (state == COLLECT) && !rx_valid && (tcnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            if (accept || expire || state != COLLECT) tcnt <= '0;
            else                                      tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_3byte_assembler.sv
// tb/tb_rx_3byte_assembler.sv - directed self-checking bench for rx_3byte_assembler (both byte orders)
module tb_rx_3byte_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        word_ready;
    logic [23:0] wo_m, wo_l;
    logic        wv_m, wv_l, ov_m, ov_l, te_m, te_l;
    logic [1:0]  bc_m, bc_l;
    int          total = 0;
    int          bad = 0;
    logic        te_seen;

    always #5 clk = ~clk;

    rx_3byte_assembler #(.TIMEOUT_CYCLES(16), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready),
        .byte_count(bc_m), .overrun(ov_m), .timeout_err(te_m)
    );

    rx_3byte_assembler #(.TIMEOUT_CYCLES(16), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready),
        .byte_count(bc_l), .overrun(ov_l), .timeout_err(te_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one input cycle at the falling edge; outputs are sampled at the next falling edge.
    task automatic step(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; word_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check("rst_wv", wv_m, 0);
        check("rst_wo", wo_m, 0);
        check("rst_bc", bc_m, 0);
        check("rst_ov", ov_m, 0);

        // basic word, both byte orders, valid exactly one cycle
        step(1, 8'h12); check("b1_bc", bc_m, 1);
        step(1, 8'h34); check("b2_bc", bc_m, 2);
        check("b2_wv", wv_m, 0);
        step(1, 8'h56);
        check("w1_wv", wv_m, 1);
        check("w1_msb", wo_m, 32'h123456);
        check("w1_lsb", wo_l, 32'h563412);
        check("w1_bc", bc_m, 0);
        step(0, 8'h00);
        check("w1_wv_drop", wv_m, 0);
        check("w1_retain", wo_m, 32'h123456);
        step(0, 8'h00);
        check("w1_ready_idle", wv_m, 0);

        // overrun while pending, then handoff with simultaneous byte
        word_ready = 1'b0;
        step(1, 8'hAA); step(1, 8'hBB); step(1, 8'hCC);
        check("w2_wv", wv_m, 1);
        check("w2_wo", wo_m, 32'hAABBCC);
        step(1, 8'h01);
        check("ovr_pulse", ov_m, 1);
        check("ovr_wo", wo_m, 32'hAABBCC);
        check("ovr_wv", wv_m, 1);
        step(0, 8'h00);
        check("ovr_end", ov_m, 0);
        check("ovr_bc", bc_m, 0);
        word_ready = 1'b1;
        step(1, 8'h02);
        check("xfer_wv", wv_m, 0);
        check("xfer_bc", bc_m, 1);
        check("xfer_ov", ov_m, 0);
        step(1, 8'h03); step(1, 8'h04);
        check("w3_msb", wo_m, 32'h020304);
        check("w3_lsb", wo_l, 32'h040302);
        step(0, 8'h00);

        // reset mid-word with coincident strobe
        step(1, 8'hE1); step(1, 8'hE2);
        check("pre_rst_bc", bc_m, 2);
        reset = 1'b1;
        step(1, 8'hEE);
        reset = 1'b0;
        check("mid_rst_bc", bc_m, 0);
        check("mid_rst_wo", wo_m, 0);
        check("mid_rst_wv", wv_m, 0);
        step(1, 8'h07); step(1, 8'h08); step(1, 8'h09);
        check("w4_msb", wo_m, 32'h070809);
        check("w4_lsb", wo_l, 32'h090807);
        step(0, 8'h00);

`ifdef RX3_TIMEOUT_EN
        step(1, 8'h11);
        for (int i = 0; i < 15; i++) step(0, 8'h00);
        check("to_before", te_m, 0);
        check("to_before_bc", bc_m, 1);
        step(0, 8'h00);
        check("to_pulse", te_m, 1);
        check("to_bc", bc_m, 0);
        step(0, 8'h00);
        check("to_end", te_m, 0);
        step(1, 8'h21); step(1, 8'h22); step(1, 8'h23);
        check("w5_msb", wo_m, 32'h212223);
        step(0, 8'h00);
        // byte arriving in the expiry cycle wins
        step(1, 8'h31);
        for (int i = 0; i < 15; i++) step(0, 8'h00);
        step(1, 8'h32);
        check("exp_win_te", te_m, 0);
        check("exp_win_bc", bc_m, 2);
        step(1, 8'h33);
        check("w6_msb", wo_m, 32'h313233);
        step(0, 8'h00);
`else
        te_seen = 1'b0;
        step(1, 8'h44);
        for (int i = 0; i < 2000; i++) begin
            step(0, 8'h00);
            te_seen = te_seen | te_m | te_l;
        end
        check("nto_bc", bc_m, 1);
        step(1, 8'h55); step(1, 8'h66);
        te_seen = te_seen | te_m | te_l;
        check("nto_te", te_seen, 0);
        check("w5_msb", wo_m, 32'h445566);
        check("w5_lsb", wo_l, 32'h665544);
        step(0, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
